// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared types and helpers for the L2 eviction write buffer
package l2_cache_pkg;

    localparam int EWB_WIDTH  = 256;
    localparam int EWB_DEPTH  = 8;
    localparam int EWB_ADDR_W = 32;
    localparam int EWB_OFFSET = 5;
    localparam int EWB_TAG_W  = EWB_ADDR_W - EWB_OFFSET;

    typedef struct packed {
        logic                 valid;
        logic [EWB_TAG_W-1:0] tag;
        logic [EWB_WIDTH-1:0] data;
    } ewb_entry_t;

    function automatic logic [EWB_TAG_W-1:0] tag_of(input logic [EWB_ADDR_W-1:0] addr);
        return addr[EWB_ADDR_W-1:EWB_OFFSET];
    endfunction

endpackage

// File: rtl/ewb_tag_match.sv
// rtl/ewb_tag_match.sv - DEPTH-way tag comparator returning one-hot match and encoded index
module ewb_tag_match #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 27
) (
    input  logic [DEPTH-1:0]            i_valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]            i_tag,
    output logic [DEPTH-1:0]            o_match,
    output logic                        o_hit,
    output logic [$clog2(DEPTH)-1:0]    o_idx
);

    localparam int IDX_W = $clog2(DEPTH);

    // OR-encoding is exact because at most one entry can match
    always_comb begin
        o_match = '0;
        o_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                o_match[i] = 1'b1;
                o_idx      = o_idx | IDX_W'(i);
            end
        end
    end

    assign o_hit = |o_match;

endmodule

// File: rtl/ewb_coalesce.sv
// rtl/ewb_coalesce.sv - coalescing eviction write buffer with lookup forwarding and byte-masked updates
module ewb_coalesce
    import l2_cache_pkg::*;
#(
    parameter int WIDTH  = EWB_WIDTH,
    parameter int DEPTH  = EWB_DEPTH,
    parameter int ADDR_W = EWB_ADDR_W,
    parameter int OFFSET = EWB_OFFSET
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [ADDR_W-OFFSET-1:0]   lkup_tag_i,
    output logic                       hit_o,
    output logic [WIDTH-1:0]           hit_data_o,
    input  logic                       upd_valid_i,
    input  logic [ADDR_W-OFFSET-1:0]   upd_tag_i,
    input  logic [WIDTH/8-1:0]         upd_be_i,
    input  logic [WIDTH-1:0]           upd_data_i,
    output logic                       upd_hit_o,
    output logic                       valid_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       yumi_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int TAG_W = ADDR_W - OFFSET;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int BE_W  = WIDTH / 8;

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [IDX_W-1:0]            r_rd_ptr;
    logic [IDX_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]            r_count;

    logic [TAG_W-1:0] w_enq_tag;
    logic [DEPTH-1:0] w_enq_match, w_lk_match, w_upd_match;
    logic             w_enq_hit, w_lk_hit, w_upd_any;
    logic [IDX_W-1:0] w_enq_idx, w_lk_idx, w_upd_idx, w_wr_idx;
    logic             w_deq, w_enq, w_enq_coal, w_enq_alloc, w_upd;
    logic             w_unused_offset;

    assign w_enq_tag       = addr_i[ADDR_W-1:OFFSET];
    assign w_unused_offset = ^addr_i[OFFSET-1:0];

    ewb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_enq_match (
        .i_valid(r_valid), .i_tags(r_tag), .i_tag(w_enq_tag),
        .o_match(w_enq_match), .o_hit(w_enq_hit), .o_idx(w_enq_idx)
    );

    ewb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lk_match (
        .i_valid(r_valid), .i_tags(r_tag), .i_tag(lkup_tag_i),
        .o_match(w_lk_match), .o_hit(w_lk_hit), .o_idx(w_lk_idx)
    );

    ewb_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_upd_match (
        .i_valid(r_valid), .i_tags(r_tag), .i_tag(upd_tag_i),
        .o_match(w_upd_match), .o_hit(w_upd_any), .o_idx(w_upd_idx)
    );

    assign valid_o = (r_count != '0);
    assign ready_o = (r_count != CNT_W'(DEPTH)) || w_enq_hit;
    assign count_o = r_count;
    assign addr_o  = {r_tag[r_rd_ptr], {OFFSET{1'b0}}};
    assign data_o  = r_data[r_rd_ptr];

    assign w_deq = yumi_i && valid_o;
    assign w_enq = valid_i && ready_o;

    // A line leaving this cycle cannot absorb a coalesce or an update; the enqueue gets a fresh slot instead
    assign w_enq_coal  = w_enq && w_enq_hit && !(w_deq && (w_enq_idx == r_rd_ptr));
    assign w_enq_alloc = w_enq && !w_enq_coal;
    assign w_upd       = upd_valid_i && w_upd_any && !(w_deq && (w_upd_idx == r_rd_ptr));
    assign w_wr_idx    = w_enq_coal ? w_enq_idx : r_wr_ptr;

    assign upd_hit_o  = w_upd;
    assign hit_o      = w_lk_hit;
    assign hit_data_o = w_lk_hit ? r_data[w_lk_idx] : '0;

    // Allocation is ordered after the dequeue clear so full+yumi can reuse the head slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_deq) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + IDX_W'(1);
            end
            if (w_enq_alloc) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + IDX_W'(1);
            end
            case ({w_enq_alloc, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Full-line enqueue data is written last so it overrides a same-entry byte update
    always_ff @(posedge clk) begin
        if (w_upd) begin
            for (int b = 0; b < BE_W; b++) begin
                if (upd_be_i[b]) begin
                    r_data[w_upd_idx][b*8 +: 8] <= upd_data_i[b*8 +: 8];
                end
            end
        end
        if (w_enq) begin
            r_data[w_wr_idx] <= data_i;
            if (w_enq_alloc) begin
                r_tag[r_wr_ptr] <= w_enq_tag;
            end
        end
    end

    a_enq_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_enq_match));
    a_lk_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(w_lk_match));
    a_upd_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_upd_match));
    a_yumi_valid: assert property (@(posedge clk) disable iff (rst) yumi_i |-> valid_o);
    a_count_pop:  assert property (@(posedge clk) disable iff (rst) r_count == CNT_W'($countones(r_valid)));

endmodule

// File: tb/tb_ewb_coalesce.sv
// tb/tb_ewb_coalesce.sv - randomized and directed bench for ewb_coalesce against a FIFO-queue model
module tb_ewb_coalesce;

    localparam int WIDTH  = 256;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int OFFSET = 5;
    localparam int TAG_W  = ADDR_W - OFFSET;
    localparam int BE_W   = WIDTH / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, ready_o;
    logic [ADDR_W-1:0] addr_i;
    logic [WIDTH-1:0]  data_i;
    logic [TAG_W-1:0]  lkup_tag_i;
    logic              hit_o;
    logic [WIDTH-1:0]  hit_data_o;
    logic              upd_valid_i;
    logic [TAG_W-1:0]  upd_tag_i;
    logic [BE_W-1:0]   upd_be_i;
    logic [WIDTH-1:0]  upd_data_i;
    logic              upd_hit_o;
    logic              valid_o;
    logic [ADDR_W-1:0] addr_o;
    logic [WIDTH-1:0]  data_o;
    logic              yumi_i;
    logic [CNT_W-1:0]  count_o;

    ewb_coalesce #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .addr_i(addr_i), .data_i(data_i),
        .lkup_tag_i(lkup_tag_i), .hit_o(hit_o), .hit_data_o(hit_data_o),
        .upd_valid_i(upd_valid_i), .upd_tag_i(upd_tag_i), .upd_be_i(upd_be_i),
        .upd_data_i(upd_data_i), .upd_hit_o(upd_hit_o),
        .valid_o(valid_o), .addr_o(addr_o), .data_o(data_o), .yumi_i(yumi_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } ment_t;

    ment_t mq[$];

    function automatic int mfind(input logic [TAG_W-1:0] t);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == t) return i;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_line();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        int h, e, u;
        logic [WIDTH-1:0] hd;
        h  = mfind(lkup_tag_i);
        e  = mfind(addr_i[ADDR_W-1:OFFSET]);
        u  = mfind(upd_tag_i);
        hd = '0;
        if (h >= 0) hd = mq[h].data;
        chk("count_o", count_o, mq.size());
        chk("valid_o", valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("addr_o", addr_o, {mq[0].tag, 5'b0});
            chk("data_o", data_o, mq[0].data);
        end
        chk("ready_o", ready_o, (mq.size() != DEPTH) || (e >= 0));
        chk("hit_o", hit_o, h >= 0);
        chk("hit_data_o", hit_data_o, hd);
        chk("upd_hit_o", upd_hit_o, upd_valid_i && (u >= 0) && !(yumi_i && u == 0));
    endtask

    task automatic model_step();
        int    u, e;
        bit    rdy;
        ment_t t;
        if (rst) begin
            mq.delete();
        end else begin
            rdy = (mq.size() != DEPTH) || (mfind(addr_i[ADDR_W-1:OFFSET]) >= 0);
            u   = mfind(upd_tag_i);
            if (upd_valid_i && u >= 0 && !(yumi_i && u == 0)) begin
                t = mq[u];
                for (int b = 0; b < BE_W; b++) begin
                    if (upd_be_i[b]) t.data[b*8 +: 8] = upd_data_i[b*8 +: 8];
                end
                mq[u] = t;
            end
            if (yumi_i && mq.size() > 0) void'(mq.pop_front());
            if (valid_i && rdy) begin
                e = mfind(addr_i[ADDR_W-1:OFFSET]);
                if (e >= 0) begin
                    t      = mq[e];
                    t.data = data_i;
                    mq[e]  = t;
                end else begin
                    t.tag  = addr_i[ADDR_W-1:OFFSET];
                    t.data = data_i;
                    mq.push_back(t);
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i     = 1'b0;
        upd_valid_i = 1'b0;
        yumi_i      = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic enq(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        idle();
        valid_i = 1'b1;
        addr_i  = a;
        data_i  = d;
        settle();
        advance();
    endtask

    logic [WIDTH-1:0] d0, d1, dn, exp_line;

    initial begin
        rst = 1'b1; valid_i = 1'b0; upd_valid_i = 1'b0; yumi_i = 1'b0;
        addr_i = '0; data_i = '0; lkup_tag_i = '0; upd_tag_i = '0; upd_be_i = '0; upd_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        mq.delete();
        idle();

        // reset state
        settle();
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_hit", hit_o, 0);
        chk("rst_upd_hit", upd_hit_o, 0);
        advance();

        // two enqueues, lookup, one dequeue
        d0 = rnd_line();
        d1 = rnd_line();
        enq(32'h1000, d0);
        enq(32'h2000, d1);
        idle();
        lkup_tag_i = 27'h80;
        settle();
        chk("two_count", count_o, 2);
        chk("two_head", addr_o, 32'h1000);
        chk("two_model_size", mq.size(), 2);
        chk("lk_hit", hit_o, 1);
        chk("lk_data", hit_data_o, d0);
        lkup_tag_i = 27'h7_5555;
        #1;
        chk("lk_miss", hit_o, 0);
        chk("lk_miss_data", hit_data_o, '0);
        yumi_i = 1'b1;
        advance();
        idle();
        settle();
        chk("deq_head", addr_o, 32'h2000);
        chk("deq_count", count_o, 1);
        yumi_i = 1'b1;
        advance();

        // fill, stall on new line, coalesce while full
        for (int k = 3; k <= 10; k++) enq(k << 12, rnd_line());
        idle();
        valid_i = 1'b1; addr_i = 32'hB000; data_i = rnd_line();
        settle();
        chk("full_stall", ready_o, 0);
        advance();
        dn = rnd_line();
        valid_i = 1'b1; addr_i = 32'h3000; data_i = dn;
        settle();
        chk("full_coal_ready", ready_o, 1);
        advance();
        idle();
        lkup_tag_i = 27'h180;
        settle();
        chk("coal_count", count_o, 8);
        chk("coal_data", hit_data_o, dn);
        advance();

        // full + yumi + new line: no enqueue, then accepted next cycle
        valid_i = 1'b1; addr_i = 32'hC000; data_i = rnd_line(); yumi_i = 1'b1;
        settle();
        chk("full_yumi_ready", ready_o, 0);
        advance();
        yumi_i = 1'b0;
        settle();
        advance();
        idle();
        settle();
        chk("refill_count", count_o, 8);
        chk("refill_head", addr_o, 32'h4000);
        advance();
        for (int k = 0; k < 8; k++) begin
            idle();
            yumi_i = 1'b1;
            settle();
            if (k == 7) chk("last_drain", addr_o, 32'hC000);
            advance();
        end

        // byte-masked updates, including one blocked by head dequeue
        enq(32'h1000, d0);
        enq(32'h2000, d1);
        idle();
        upd_valid_i = 1'b1; upd_tag_i = 27'h100; upd_be_i = 32'h0000000F;
        upd_data_i = rnd_line();
        upd_data_i[31:0] = 32'hAABBCCDD;
        settle();
        chk("upd_hit", upd_hit_o, 1);
        advance();
        upd_tag_i = 27'h80; yumi_i = 1'b1;
        settle();
        chk("upd_head_blocked", upd_hit_o, 0);
        chk("upd_head_data", data_o, d0);
        advance();
        idle();
        exp_line = {d1[WIDTH-1:32], 32'hAABBCCDD};
        settle();
        chk("upd_drain", data_o, exp_line);
        chk("upd_model", mq[0].data, exp_line);
        yumi_i = 1'b1;
        advance();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst         = ($urandom_range(0, 199) == 0);
            valid_i     = $urandom_range(0, 1);
            addr_i      = ($urandom_range(1, 12) << 12) | $urandom_range(0, 31);
            data_i      = rnd_line();
            upd_valid_i = ($urandom_range(0, 9) < 3);
            upd_tag_i   = $urandom_range(1, 12) << 7;
            upd_be_i    = $urandom;
            upd_data_i  = rnd_line();
            lkup_tag_i  = ($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'($urandom_range(1, 12) << 7);
            yumi_i      = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            settle();
            advance();
        end

        // reset with five entries queued
        idle();
        yumi_i = 1'b1;
        while (mq.size() > 0) begin
            settle();
            advance();
        end
        for (int k = 1; k <= 5; k++) enq(k << 12, rnd_line());
        idle();
        rst = 1'b1;
        settle();
        chk("pre_rst_count", count_o, 5);
        advance();
        idle();
        settle();
        chk("post_rst_count", count_o, 0);
        chk("post_rst_valid", valid_o, 0);
        for (int k = 1; k <= 5; k++) begin
            lkup_tag_i = 27'(k << 7);
            #1;
            chk("post_rst_hit", hit_o, 0);
        end
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
